// File: rtl/nor_flash_responder.sv
// Device-side parallel NOR flash model: JEDEC unlock/command decode, word program, sector erase, RY/BY#.
// Define NOR_RESP_CFI_EN to add the CFI query mode and its ROM.
module nor_flash_responder #(
  parameter int ADDRBITS    = 26,
  parameter int DATABITS    = 16,
  parameter int MEMBITS     = 10,
  parameter int SECTORBITS  = 6,
  parameter int SYNC_STAGES = 2,
  parameter int PROG_CYCLES = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                nor_ce_i,
  input  logic                nor_we_i,
  input  logic                nor_oe_i,
  input  logic [ADDRBITS-1:0] nor_addr_i,
  input  logic [DATABITS-1:0] nor_data_i,
  output logic [DATABITS-1:0] nor_data_o,
  output logic                nor_data_oe,
  output logic                nor_ry_o
);

  localparam int CNTW       = (SECTORBITS + 1 > 8) ? SECTORBITS + 1 : 8;
  localparam int LATCHW     = (MEMBITS > 12) ? MEMBITS : 12;
  localparam int DEPTH      = 1 << MEMBITS;
  localparam int ERASE_LAST = (1 << SECTORBITS) - 1;
  localparam logic [MEMBITS-1:0] SECT_MASK = MEMBITS'(ERASE_LAST);

  typedef enum logic [3:0] {
    S_READ_ARRAY, S_UNLOCK1, S_UNLOCK2, S_PROG_SETUP, S_ERASE_SETUP,
    S_ERASE_U1, S_ERASE_U2, S_BUSY_PROG, S_BUSY_ERASE, S_CFI_QUERY
  } state_e;

  logic [SYNC_STAGES-1:0] ce_sync_q, ce_sync_d, we_sync_q, we_sync_d, oe_sync_q, oe_sync_d;
  logic [ADDRBITS-1:0]    addr_sync_q [SYNC_STAGES];
  logic [ADDRBITS-1:0]    addr_sync_d [SYNC_STAGES];
  logic [DATABITS-1:0]    data_sync_q [SYNC_STAGES];
  logic [DATABITS-1:0]    data_sync_d [SYNC_STAGES];

  state_e                 state_q, state_d;
  logic                   ry_q, ry_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic                   toggle_q, toggle_d;
  logic                   rsel_q, wsel_q;
  logic [LATCHW-1:0]      wr_addr_q, wr_addr_d;
  logic [DATABITS-1:0]    wr_data_q, wr_data_d;
  logic [MEMBITS-1:0]     prog_addr_q, prog_addr_d;
  logic [DATABITS-1:0]    prog_data_q, prog_data_d;
  logic [MEMBITS-1:0]     erase_base_q, erase_base_d;
  logic [DATABITS-1:0]    data_q, data_d;
  logic                   data_oe_q, data_oe_d;

  logic [DATABITS-1:0]    mem [DEPTH];
  logic                   mem_we;
  logic [MEMBITS-1:0]     mem_waddr;
  logic [DATABITS-1:0]    mem_wdata;

  logic                   ce_s, we_s, oe_s, wsel, rsel, commit, busy;
  logic [ADDRBITS-1:0]    addr_s;
  logic [DATABITS-1:0]    data_s;
  logic [11:0]            cmd_addr;
  logic [7:0]             cmd_data;
  logic [DATABITS-1:0]    status;
  logic                   unused_addr_hi;

`ifdef NOR_RESP_CFI_EN
  function automatic logic [DATABITS-1:0] cfi_rom(input logic [11:0] a);
    case (a)
      12'h010: cfi_rom = DATABITS'(16'h0051);
      12'h011: cfi_rom = DATABITS'(16'h0052);
      12'h012: cfi_rom = DATABITS'(16'h0059);
      12'h027: cfi_rom = DATABITS'(MEMBITS + 1);
      default: cfi_rom = '0;
    endcase
  endfunction
`endif

  always_comb begin : sync_next
    ce_sync_d      = ce_sync_q;
    we_sync_d      = we_sync_q;
    oe_sync_d      = oe_sync_q;
    addr_sync_d    = addr_sync_q;
    data_sync_d    = data_sync_q;
    ce_sync_d[0]   = nor_ce_i;
    we_sync_d[0]   = nor_we_i;
    oe_sync_d[0]   = nor_oe_i;
    addr_sync_d[0] = nor_addr_i;
    data_sync_d[0] = nor_data_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      ce_sync_d[i]   = ce_sync_q[i-1];
      we_sync_d[i]   = we_sync_q[i-1];
      oe_sync_d[i]   = oe_sync_q[i-1];
      addr_sync_d[i] = addr_sync_q[i-1];
      data_sync_d[i] = data_sync_q[i-1];
    end
  end

  assign ce_s   = ce_sync_q[SYNC_STAGES-1];
  assign we_s   = we_sync_q[SYNC_STAGES-1];
  assign oe_s   = oe_sync_q[SYNC_STAGES-1];
  assign addr_s = addr_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  // A write lands when the synchronized write select drops, using the last address/data seen while it was high.
  assign wsel     = !ce_s && !we_s;
  assign rsel     = !ce_s && !oe_s && we_s;
  assign commit   = wsel_q && !wsel;
  assign busy     = (state_q == S_BUSY_PROG) || (state_q == S_BUSY_ERASE);
  assign cmd_addr = wr_addr_q[11:0];
  assign cmd_data = wr_data_q[7:0];
  assign unused_addr_hi = ^addr_s[ADDRBITS-1:LATCHW];

  always_comb begin : next_state
    state_d      = state_q;
    ry_d         = ry_q;
    cnt_d        = cnt_q;
    prog_addr_d  = prog_addr_q;
    prog_data_d  = prog_data_q;
    erase_base_d = erase_base_q;
    wr_addr_d    = wsel ? addr_s[LATCHW-1:0] : wr_addr_q;
    wr_data_d    = wsel ? data_s : wr_data_q;
    mem_we       = 1'b0;
    mem_waddr    = prog_addr_q;
    mem_wdata    = mem[prog_addr_q] & prog_data_q;
    case (state_q)
      S_BUSY_PROG: begin
        mem_we = (cnt_q == '0);
        if (cnt_q == CNTW'(PROG_CYCLES - 1)) begin
          state_d = S_READ_ARRAY;
          ry_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_BUSY_ERASE: begin
        mem_we    = 1'b1;
        mem_waddr = erase_base_q | MEMBITS'(cnt_q);
        mem_wdata = '1;
        if (cnt_q == CNTW'(ERASE_LAST)) begin
          state_d = S_READ_ARRAY;
          ry_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: begin
        if (commit) begin
          state_d = S_READ_ARRAY;
          if (cmd_data != 8'hF0) begin
            case (state_q)
              S_READ_ARRAY: begin
                if (cmd_addr == 12'h555 && cmd_data == 8'hAA) state_d = S_UNLOCK1;
`ifdef NOR_RESP_CFI_EN
                if (cmd_addr == 12'h055 && cmd_data == 8'h98) state_d = S_CFI_QUERY;
`endif
              end
              S_UNLOCK1:
                if (cmd_addr == 12'h2AA && cmd_data == 8'h55) state_d = S_UNLOCK2;
              S_UNLOCK2: begin
                if (cmd_addr == 12'h555 && cmd_data == 8'hA0) state_d = S_PROG_SETUP;
                if (cmd_addr == 12'h555 && cmd_data == 8'h80) state_d = S_ERASE_SETUP;
              end
              S_PROG_SETUP: begin
                prog_addr_d = wr_addr_q[MEMBITS-1:0];
                prog_data_d = wr_data_q;
                state_d     = S_BUSY_PROG;
                ry_d        = 1'b0;
                cnt_d       = '0;
              end
              S_ERASE_SETUP:
                if (cmd_addr == 12'h555 && cmd_data == 8'hAA) state_d = S_ERASE_U1;
              S_ERASE_U1:
                if (cmd_addr == 12'h2AA && cmd_data == 8'h55) state_d = S_ERASE_U2;
              S_ERASE_U2: begin
                if (cmd_data == 8'h30) begin
                  erase_base_d = wr_addr_q[MEMBITS-1:0] & ~SECT_MASK;
                  state_d      = S_BUSY_ERASE;
                  ry_d         = 1'b0;
                  cnt_d        = '0;
                end
              end
              S_CFI_QUERY: state_d = S_CFI_QUERY;
              default: state_d = S_READ_ARRAY;
            endcase
          end
        end
      end
    endcase
  end

  // While busy the master polls status; DQ6 flips on every new read access so it can see progress.
  always_comb begin : read_path
    toggle_d = toggle_q;
    if (rsel && !rsel_q && busy) toggle_d = ~toggle_q;
    status    = '0;
    status[7] = (state_q == S_BUSY_PROG) ? ~prog_data_q[7] : 1'b0;
    status[6] = toggle_d;
    data_oe_d = rsel;
    data_d    = data_q;
    if (rsel) begin
      if (busy) data_d = status;
`ifdef NOR_RESP_CFI_EN
      else if (state_q == S_CFI_QUERY) data_d = cfi_rom(addr_s[11:0]);
`endif
      else data_d = mem[addr_s[MEMBITS-1:0]];
    end
  end

  always_ff @(posedge clk_i) begin : regs
    if (!rst_ni) begin
      ce_sync_q <= '1;
      we_sync_q <= '1;
      oe_sync_q <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        addr_sync_q[i] <= '0;
        data_sync_q[i] <= '0;
      end
      state_q      <= S_READ_ARRAY;
      ry_q         <= 1'b1;
      cnt_q        <= '0;
      toggle_q     <= 1'b0;
      rsel_q       <= 1'b0;
      wsel_q       <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      prog_addr_q  <= '0;
      prog_data_q  <= '0;
      erase_base_q <= '0;
      data_q       <= '0;
      data_oe_q    <= 1'b0;
    end else begin
      ce_sync_q    <= ce_sync_d;
      we_sync_q    <= we_sync_d;
      oe_sync_q    <= oe_sync_d;
      addr_sync_q  <= addr_sync_d;
      data_sync_q  <= data_sync_d;
      state_q      <= state_d;
      ry_q         <= ry_d;
      cnt_q        <= cnt_d;
      toggle_q     <= toggle_d;
      rsel_q       <= rsel;
      wsel_q       <= wsel;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      prog_addr_q  <= prog_addr_d;
      prog_data_q  <= prog_data_d;
      erase_base_q <= erase_base_d;
      data_q       <= data_d;
      data_oe_q    <= data_oe_d;
    end
  end

  // The array survives reset; a reset in the middle of an operation only stops further writes.
  always_ff @(posedge clk_i) begin : array_write
    if (rst_ni && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign nor_data_o  = data_q;
  assign nor_data_oe = data_oe_q;
  assign nor_ry_o    = ry_q;

endmodule

// File: doc/nor_flash_responder.md
Name: nor_flash_responder

Overview:
Synthesizable target-side model of a parallel NOR flash. It sits on the device side of the NOR pins and answers the CE/WE/OE/RY protocol driven by the team's NOR bus master. It decodes JEDEC-style unlock/command sequences and implements read-array, word program and sector erase on an internal word array, with RY/BY# busy signalling. Used for bring-up, emulation and closed-loop simulation of the bridge.

Parameters:
ADDRBITS, 26, width of the NOR address bus.
DATABITS, 16, width of the NOR data bus.
MEMBITS, 10, log2 of the internal array depth in words. Address bits above MEMBITS alias.
SECTORBITS, 6, log2 of sector size in words. Must be at most MEMBITS.
SYNC_STAGES, 2, synchronizer depth on all NOR inputs. Must be at least 1.
PROG_CYCLES, 16, busy clocks per word program. Range 1..255.

Ports:
clk_i  in  1  system clock
rst_ni  in  1  synchronous reset, active low
nor_ce_i  in  1  chip enable, active low
nor_we_i  in  1  write enable, active low
nor_oe_i  in  1  output enable, active low
nor_addr_i  in  ADDRBITS  word address
nor_data_i  in  DATABITS  write data from master
nor_data_o  out  DATABITS  read data to master
nor_data_oe  out  1  1 = responder drives data bus
nor_ry_o  out  1  1 = ready, 0 = busy

Behaviour:
- Interface: one clock (clk_i); reset is synchronous, active-low (rst_ni). No other clocks or resets.
- Reset values: nor_data_o=0, nor_data_oe=0, nor_ry_o=1, command FSM=READ_ARRAY, toggle bit=0, synchronizers cleared to ce/we/oe=1.
  - The array is not cleared by reset.
  - A reset during a busy operation aborts it. Words already written stay written.
- Input sampling:
  - ce/we/oe, addr and data all pass through SYNC_STAGES flops.
  - Define the following on synchronized signals:
    - wsel = !ce & !we
    - rsel = !ce & !oe & we
- Write commit:
  - Occurs on the cycle wsel goes 1->0.
  - Uses addr/data from the last sample where wsel=1.
  - Command address match uses addr[11:0] only: 0x555, 0x2AA.
- Read path:
  - While rsel=1: nor_data_oe=1 and nor_data_o is registered every cycle.
  - Latency is SYNC_STAGES+1 clocks from the pin edge.
  - Data source:
    - ready: mem[addr[MEMBITS-1:0]] (or CFI ROM, see below)
    - busy: status word {DQ7=0 for erase, DQ7=~programmed DQ7 for program; DQ6=toggle; all other bits 0}
  - The toggle bit inverts on each rsel 0->1 while busy.
  - With rsel=0, nor_data_oe=0 and nor_data_o holds its last value.
- Command FSM (evaluated at write commit only):
  - READ_ARRAY: 0x555/0xAA -> UNLOCK1.
  - UNLOCK1: 0x2AA/0x55 -> UNLOCK2.
  - UNLOCK2, at 0x555:
    - 0xA0 -> PROG_SETUP
    - 0x80 -> ERASE_SETUP
    - 0xF0 -> READ_ARRAY
  - PROG_SETUP: any address/data:
    - Latch addr/data.
    - mem <= mem & data; bits can only clear.
    - Write occurs on the first busy cycle.
    - -> BUSY_PROG, ry=0, counter=0.
  - ERASE_SETUP: 0x555/0xAA -> ERASE_U1.
  - ERASE_U1: 0x2AA/0x55 -> ERASE_U2.
  - ERASE_U2: data 0x30 at any address:
    - Latch sector = addr[MEMBITS-1:SECTORBITS].
    - -> BUSY_ERASE, ry=0.
  - Any non-matching write in a non-busy state -> READ_ARRAY.
  - Data 0xF0 at any address in any non-busy state -> READ_ARRAY.
  - Only low 8 data bits are compared for commands.
- BUSY_PROG:
  - Counter counts PROG_CYCLES clocks.
  - On the final cycle: ry=1 and the FSM returns to READ_ARRAY.
  - ry rises exactly PROG_CYCLES clocks after the commit.
- BUSY_ERASE:
  - Writes all-ones to one word per clock, word index 0..2^SECTORBITS-1 within the sector.
  - After the last word: ry=1 and the FSM returns to READ_ARRAY.
  - Busy duration is 2^SECTORBITS clocks.
- Writes committed while busy are ignored, including 0xF0.
- Reads while busy return status, never array data.
- Simultaneous rsel and wsel cannot occur, since rsel requires we=1.
- A CE rise while we=0 commits the write (wsel 1->0).
- A program-commit address at the last array word aliases with no wrap error.

Optional Feature:
NOR_RESP_CFI_EN
- Defined:
  - Write 0x98 at addr[11:0]=0x055 from READ_ARRAY (no unlock) -> CFI_QUERY.
  - In CFI_QUERY, reads return a ROM: 0x10='Q'(0x0051), 0x11='R'(0x0052), 0x12='Y'(0x0059), 0x27=MEMBITS+1 (byte size log2), and 0x0000 elsewhere.
  - 0xF0 at any address -> READ_ARRAY.
  - Other writes are ignored.
- Undefined: 0x98 is a non-matching write; the FSM stays in or returns to READ_ARRAY and no ROM is synthesized.

Test Plan:
- Reset then idle: nor_ry_o=1, nor_data_oe=0 throughout. Read of addr 0x000 with oe low drives nor_data_oe=1 after SYNC_STAGES+1 clocks.
- Erase sector 0 (AA@555, 55@2AA, 80@555, AA@555, 55@2AA, 30@0x000):
  - ry low for exactly 64 clocks.
  - Reads during busy show DQ6 alternating 0x0040/0x0000.
  - Afterwards, reads of 0x000 and 0x03F return 0xFFFF.
- Program 0x1234 at 0x005 after erase: ry low for 16 clocks, then read of 0x005 returns 0x1234. Programming 0xFF00 to the same word then reads 0x1200.
- Broken sequence AA@555, 55@0x123: the next write A0@555 does not program, and reads of 0x555 return array data.
- Reset asserted 10 clocks into a sector-1 erase: ry=1 immediately after reset. Words 0x040..0x049 read 0xFFFF, word 0x04A retains its old value.
- With NOR_RESP_CFI_EN: 98@055, then reads of 0x010/0x011/0x012 return 0x0051/0x0052/0x0059. After F0, the array is visible again.
